// File: rtl/inc_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inc_fsm_pkg                                                   |
// | Brief    : Shared state type and default state encodings for inc_fsm.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package inc_fsm_pkg;

   // One-bit state register type; the encoding is set per instance.
   typedef logic state_t;

   // Default encodings of the "low" and "high" states.
   localparam state_t STATE_S0_DEF = 1'b0;
   localparam state_t STATE_S1_DEF = 1'b1;

endpackage : inc_fsm_pkg
`default_nettype wire

// File: rtl/inc_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inc_fsm                                                       |
// | Brief    : Two-state up/down controller. Moore level c marks the high    |
// |            state; Mealy pulses inc/dec flag the cycle a legal            |
// |            transition is taken.                                          |
// | Options  : INC_FSM_ASSERT_EN - compiles in simulation-only checks.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module inc_fsm
   import inc_fsm_pkg::*;
#(
   parameter state_t S1 = STATE_S1_DEF,
   parameter state_t S0 = STATE_S0_DEF
) (
   input  logic u,
   input  logic d,
   input  logic reset,
   input  logic clk,
   output logic inc,
   output logic dec,
   output logic c
);

   state_t state_q;
   state_t state_d;

   // State register with synchronous reset to the low state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, Moore level and Mealy pulses. Any state value other than
   // S0/S1 (e.g. unknown before reset) falls back to S0 with all outputs low.
   always_comb begin
      state_d = S0;
      inc     = 1'b0;
      dec     = 1'b0;
      c       = 1'b0;
      case (state_q)
         S0: begin
            state_d = S0;
            if (u && !d) begin
               state_d = S1;
               inc     = 1'b1;
            end
         end
         S1: begin
            state_d = S1;
            c       = 1'b1;
            if (d && !u) begin
               state_d = S0;
               dec     = 1'b1;
            end
         end
         default: begin
            state_d = S0;
         end
      endcase
      // Reset suppresses any pending pulse in the same cycle.
      if (reset) begin
         inc = 1'b0;
         dec = 1'b0;
      end
   end

`ifdef INC_FSM_ASSERT_EN
   logic chk_inc_q;
   logic chk_dec_q;
   logic chk_rst_seen_q;

   // Simulation checks: exclusive pulses, pulse/level consistency across the
   // edge, and a legal state once reset has been applied.
   always_ff @(posedge clk) begin
      chk_inc_q <= inc;
      chk_dec_q <= dec;
      if (reset) begin
         chk_rst_seen_q <= 1'b1;
      end
      if (inc && dec) begin
         $error("inc_fsm: inc and dec asserted together");
      end
      if (inc && c) begin
         $error("inc_fsm: inc asserted while already in high state");
      end
      if (dec && !c) begin
         $error("inc_fsm: dec asserted while already in low state");
      end
      if (chk_inc_q && !c) begin
         $error("inc_fsm: inc not followed by high state");
      end
      if (chk_dec_q && c) begin
         $error("inc_fsm: dec not followed by low state");
      end
      if (chk_rst_seen_q && (state_q !== S0) && (state_q !== S1)) begin
         $error("inc_fsm: illegal state after reset");
      end
   end
`endif

endmodule : inc_fsm
`default_nettype wire

// File: tb/tb_inc_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_inc_fsm                                                    |
// | Brief    : Scoreboard bench for inc_fsm, default and swapped encodings.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_inc_fsm;

   typedef struct {
      bit inc;
      bit dec;
      bit c;
      bit c_chk;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic u     = 1'b1;
   logic d     = 1'b0;

   logic inc_a, dec_a, c_a;
   logic inc_b, dec_b, c_b;

   exp_t exp_q[$];
   int   tests  = 0;
   int   fails  = 0;

   // Reference model: is the controller in its high state, and is that known.
   bit   hi       = 1'b0;
   bit   hi_known = 1'b0;

   always #5 clk = ~clk;

   inc_fsm u_dut_a (
      .u     (u),
      .d     (d),
      .reset (reset),
      .clk   (clk),
      .inc   (inc_a),
      .dec   (dec_a),
      .c     (c_a)
   );

   inc_fsm #(
      .S1 (1'b0),
      .S0 (1'b1)
   ) u_dut_b (
      .u     (u),
      .d     (d),
      .reset (reset),
      .clk   (clk),
      .inc   (inc_b),
      .dec   (dec_b),
      .c     (c_b)
   );

   task automatic check(input string name, input bit act, input bit exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs just after an edge and queue what the
   // outputs must look like for that cycle.
   task automatic step(input bit r, input bit uu, input bit dd);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r;
      u     = uu;
      d     = dd;
      e.c     = hi;
      e.c_chk = hi_known;
      e.inc   = !r && hi_known && !hi && uu && !dd;
      e.dec   = !r && hi_known && hi && dd && !uu;
      exp_q.push_back(e);
      if (r) begin
         hi       = 1'b0;
         hi_known = 1'b1;
      end else if (hi_known) begin
         if (uu && !dd)      hi = 1'b1;
         else if (dd && !uu) hi = 1'b0;
      end
   endtask

   // Monitor: mid-cycle, compare both instances against the queued entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("inc_a", inc_a, e.inc);
            check("dec_a", dec_a, e.dec);
            check("inc_b", inc_b, e.inc);
            check("dec_b", dec_b, e.dec);
            if (e.c_chk) begin
               check("c_a", c_a, e.c);
               check("c_b", c_b, e.c);
            end
         end
      end
   end

   initial begin
      int r_pct;
      int guard;
      // Reset with u held high, then directed up/down/saturation/conflict.
      step(1, 1, 0);
      step(0, 0, 0);
      step(0, 1, 0);   // up
      step(0, 0, 0);   // high, no pulse
      step(0, 1, 0);   // saturated up
      step(0, 1, 1);   // conflict in high
      step(0, 0, 1);   // down
      step(0, 0, 1);   // saturated down
      step(0, 1, 1);   // conflict in low
      step(0, 1, 0);   // up
      step(1, 0, 1);   // reset mid-operation suppresses dec
      step(0, 0, 0);   // low after reset
      step(1, 1, 0);   // reset suppresses inc
      step(0, 0, 0);
      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         r_pct = $urandom_range(0, 99);
         step(r_pct < 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      step(0, 0, 0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_inc_fsm
`default_nettype wire
